// File: rtl/timer_pkg.sv
// timer_pkg: shared scheduler state encoding and round-robin pick helper
//   sched_state_t : one-hot FSM states IDLE, RUN, FINISH
//   rr_pick       : first set bit of req at or above ptr, wrapping modulo n
//                   (req up to 16 bits, ptr and result up to 4 bits)
package timer_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'b001,
      RUN    = 3'b010,
      FINISH = 3'b100
   } sched_state_t;
   // Scans from the farthest offset back towards ptr, so the nearest set bit is the last one written.
   function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
      logic [3:0] w;
      int idx;
      w = ptr;
      for (int k = 15; k >= 0; k--) begin
         idx = (int'(ptr) + k) % n;
         if (k < n && req[4'(idx)]) w = 4'(idx);
      end
      return w;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin winner selection
//   REQ    : per-requester request levels
//   PTR    : highest-priority index for this pick
//   WINNER : index of the first set REQ bit at or above PTR, wrapping at R-1
//   VALID  : high when any REQ bit is set
module rr_arbiter import timer_pkg::*; #(
   parameter int R = 4
) (
   input  logic [R-1:0]         REQ,
   input  logic [$clog2(R)-1:0] PTR,
   output logic [$clog2(R)-1:0] WINNER,
   output logic                 VALID
);
   localparam int PW = $clog2(R);
   logic [3:0] pick;
   assign pick = rr_pick(16'(REQ), 4'(PTR), R);
   assign WINNER = PW'(pick);
   assign VALID = |REQ;
endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: one countdown timer shared round-robin between R requesters
//   CLK, RESET : rising-edge clock, synchronous active-high reset
//   REQ        : request levels, held until DONE or dropped to abort
//   DUR        : packed durations, requester i at [i*W +: W], sampled only at grant
//   GNT, DONE  : one-hot grant (RUN and FINISH) and one-cycle completion pulse
//   BUSY       : high in RUN and FINISH
//   OWNER      : current or last owner index
//   COUNT      : remaining count, 0 in IDLE
module timer_scheduler import timer_pkg::*; #(
   parameter int R = 4,
   parameter int W = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [R-1:0]         REQ,
   input  logic [R*W-1:0]       DUR,
   output logic [R-1:0]         GNT,
   output logic [R-1:0]         DONE,
   output logic                 BUSY,
   output logic [$clog2(R)-1:0] OWNER,
   output logic [W-1:0]         COUNT
);
   localparam int PW = $clog2(R);
   sched_state_t state;
   logic [PW-1:0] ptr, win, nxt;
   logic vld;
   logic [R-1:0][W-1:0] dur_a;
   assign dur_a = DUR;
   // Pointer wraps explicitly so non-power-of-two R never yields an index >= R.
   assign nxt = (OWNER == PW'(R - 1)) ? '0 : OWNER + PW'(1);
   rr_arbiter #(.R(R)) u_arb (
      .REQ(REQ),
      .PTR(ptr),
      .WINNER(win),
      .VALID(vld)
   );
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         ptr   <= '0;
         OWNER <= '0;
         COUNT <= '0;
         GNT   <= '0;
         DONE  <= '0;
         BUSY  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (vld) begin
               state <= RUN;
               OWNER <= win;
               COUNT <= (dur_a[win] == '0) ? W'(1) : dur_a[win];
               GNT   <= R'(1) << win;
               BUSY  <= 1'b1;
            end
            // A dropped request aborts silently; it still costs the owner its turn.
            RUN: if (!REQ[OWNER]) begin
               state <= IDLE;
               GNT   <= '0;
               BUSY  <= 1'b0;
               COUNT <= '0;
               ptr   <= nxt;
            end else if (COUNT == W'(1)) begin
               state <= FINISH;
               DONE  <= GNT;
            end else begin
               COUNT <= COUNT - W'(1);
            end
            FINISH: begin
               state <= IDLE;
               DONE  <= '0;
               GNT   <= '0;
               BUSY  <= 1'b0;
               COUNT <= '0;
               ptr   <= nxt;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: directed vector table plus multi-cycle sequences for timer_scheduler
module tb_timer_scheduler;
   localparam int R = 4;
   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [R-1:0] REQ;
   logic [R*W-1:0] DUR;
   logic [R-1:0] GNT, DONE;
   logic         BUSY;
   logic [1:0]   OWNER;
   logic [W-1:0] COUNT;

   int total = 0;
   int bad = 0;

   timer_scheduler #(.R(R), .W(W)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .REQ(REQ),
      .DUR(DUR),
      .GNT(GNT),
      .DONE(DONE),
      .BUSY(BUSY),
      .OWNER(OWNER),
      .COUNT(COUNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] dur;
      int          owner;
      int          len;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // One complete granted interval; DUT must be idle on entry and is idle on exit.
   task automatic run_vec(input vec_t v);
      logic [3:0] oh;
      oh = 4'b0001 << v.owner;
      REQ = v.req;
      DUR = v.dur;
      tick;
      chk("grant_gnt", 32'(GNT), 32'(oh));
      chk("grant_owner", 32'(OWNER), v.owner);
      chk("grant_busy", 32'(BUSY), 1);
      DUR = ~v.dur;
      for (int k = 0; k < v.len; k++) begin
         chk("run_count", 32'(COUNT), v.len - k);
         chk("run_done", 32'(DONE), 0);
         tick;
      end
      chk("finish_done", 32'(DONE), 32'(oh));
      chk("finish_gnt", 32'(GNT), 32'(oh));
      chk("finish_busy", 32'(BUSY), 1);
      REQ = '0;
      tick;
      chk("idle_gnt", 32'(GNT), 0);
      chk("idle_done", 32'(DONE), 0);
      chk("idle_busy", 32'(BUSY), 0);
      chk("idle_count", 32'(COUNT), 0);
      chk("idle_owner", 32'(OWNER), v.owner);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen, ng, last, wide;
      logic [3:0] prev_gnt, prev_done;
      int exp_rr[5];
      exp_rr = '{0, 1, 2, 3, 0};

      tbl[0] = '{4'b0001, 32'h0000_0005, 0, 5};
      tbl[1] = '{4'b0001, 32'h0000_0000, 0, 1};
      tbl[2] = '{4'b1001, 32'h0700_0003, 3, 7};
      tbl[3] = '{4'b1001, 32'h0700_0003, 0, 3};
      tbl[4] = '{4'b0110, 32'h0009_0400, 1, 4};
      tbl[5] = '{4'b0011, 32'h0000_0602, 0, 2};
      tbl[6] = '{4'b1111, 32'hFFFF_FFFF, 1, 255};
      tbl[7] = '{4'b0100, 32'h0001_0000, 2, 1};

      // Reset state, then reset in the middle of an interval.
      RESET = 1'b1;
      REQ = '0;
      DUR = '0;
      tick;
      tick;
      chk("rst_gnt", 32'(GNT), 0);
      chk("rst_done", 32'(DONE), 0);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_count", 32'(COUNT), 0);
      chk("rst_owner", 32'(OWNER), 0);
      RESET = 1'b0;
      REQ = 4'b0100;
      DUR = 32'h000A_0000;
      tick;
      chk("mid_gnt", 32'(GNT), 32'h4);
      chk("mid_count", 32'(COUNT), 10);
      tick;
      tick;
      tick;
      chk("mid_count4", 32'(COUNT), 7);
      RESET = 1'b1;
      tick;
      RESET = 1'b0;
      chk("mid_rst_gnt", 32'(GNT), 0);
      chk("mid_rst_busy", 32'(BUSY), 0);
      chk("mid_rst_count", 32'(COUNT), 0);
      chk("mid_rst_owner", 32'(OWNER), 0);
      chk("mid_rst_done", 32'(DONE), 0);
      REQ = '0;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         tick;
         if (DONE != 0) seen++;
      end
      chk("mid_rst_no_done", seen, 0);

      foreach (tbl[i]) run_vec(tbl[i]);

      // All four requesting continuously: strict rotation, one idle cycle between grants.
      RESET = 1'b1;
      REQ = 4'b1111;
      DUR = 32'h0202_0202;
      tick;
      RESET = 1'b0;
      ng = 0;
      last = 0;
      wide = 0;
      prev_gnt = '0;
      prev_done = '0;
      for (int c = 1; c <= 22; c++) begin
         tick;
         if (GNT != 0 && prev_gnt == 0) begin
            if (ng < 5) begin
               chk("rr_owner", 32'(OWNER), exp_rr[ng]);
               chk("rr_gnt", 32'(GNT), 1 << exp_rr[ng]);
               if (ng > 0) chk("rr_gap", c - last, 4);
            end
            last = c;
            ng++;
         end
         if (DONE != 0 && prev_done != 0) wide++;
         prev_gnt = GNT;
         prev_done = DONE;
      end
      chk("rr_grants", 32'(ng >= 5), 1);
      chk("rr_done_width", wide, 0);

      // Abort of requester 1 while requester 3 waits.
      RESET = 1'b1;
      REQ = '0;
      tick;
      RESET = 1'b0;
      REQ = 4'b0010;
      DUR = 32'h0100_1400;
      tick;
      chk("ab_gnt", 32'(GNT), 32'h2);
      REQ = 4'b1010;
      tick;
      tick;
      chk("ab_count", 32'(COUNT), 18);
      REQ = 4'b1000;
      tick;
      chk("ab_gnt_off", 32'(GNT), 0);
      chk("ab_busy", 32'(BUSY), 0);
      chk("ab_done", 32'(DONE), 0);
      chk("ab_count0", 32'(COUNT), 0);
      chk("ab_owner", 32'(OWNER), 1);
      tick;
      chk("ab_next_gnt", 32'(GNT), 32'h8);
      chk("ab_next_owner", 32'(OWNER), 3);
      chk("ab_next_count", 32'(COUNT), 1);
      tick;
      chk("ab_next_done", 32'(DONE), 32'h8);
      REQ = '0;
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
